// File: rtl/alu_ctrl_mc_if.sv
// Bus between the main decoder and the ALU controller: decode inputs plus the
// ALU select and multi-cycle sequencing strobes.
interface alu_ctrl_mc_if #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CTRL_W  = 4
);
  logic               valid_i;
  logic               flush_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               mc_start_o;
  logic               mc_step_o;
  logic               mc_last_o;
  logic               stall_o;
  logic               illegal_o;

  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i,
    input  ALUCtrl_o, mc_start_o, mc_step_o, mc_last_o, stall_o, illegal_o
  );

  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i,
    output ALUCtrl_o, mc_start_o, mc_step_o, mc_last_o, stall_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// ALU controller: single-cycle decode plus sequencing of multi-cycle MULT/DIVU.
// Optional performance counters are enabled with the ALU_CTRL_PERF_EN macro.
module alu_ctrl_mc #(
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 32,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_ctrl_mc_if.slave       bus
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_o,
  output logic [31:0]        perf_mcops_o
`endif
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  localparam logic [CTRL_W-1:0] OpAdd  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OpSub  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OpAnd  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OpOr   = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OpSlt  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] OpAddi = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OpLw   = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OpSw   = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OpSlti = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OpBeq  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] OpMult = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] OpDivu = CTRL_W'(4'b1011);
  localparam logic [CTRL_W-1:0] OpSll  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OpSrl  = CTRL_W'(4'b1101);
  localparam logic [CTRL_W-1:0] OpNop  = CTRL_W'(4'b1111);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Counter load leaves LAT-1 BUSY cycles after the IDLE start cycle.
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 2);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 2);

  if (MUL_LAT < 2) begin : g_bad_mul_lat
    $error("MUL_LAT must be at least 2");
  end
  if (DIV_LAT < 2) begin : g_bad_div_lat
    $error("DIV_LAT must be at least 2");
  end

  logic [0:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0] op_q, op_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_mc;
  logic              go;

  always_comb begin
    dec_ctrl    = OpNop;
    dec_illegal = 1'b0;
    case (bus.ALUOp_i)
      3'b000: dec_ctrl = OpLw;
      3'b001: dec_ctrl = OpBeq;
      3'b010: begin
        case (bus.funct_i)
          6'b100000: dec_ctrl = OpAdd;
          6'b100010: dec_ctrl = OpSub;
          6'b100100: dec_ctrl = OpAnd;
          6'b100101: dec_ctrl = OpOr;
          6'b101010: dec_ctrl = OpSlt;
          6'b000000: dec_ctrl = OpSll;
          6'b000010: dec_ctrl = OpSrl;
          6'b011000: dec_ctrl = OpMult;
          6'b011011: dec_ctrl = OpDivu;
          default:   dec_illegal = 1'b1;
        endcase
      end
      3'b011:  dec_ctrl = OpAddi;
      3'b100:  dec_ctrl = OpSlti;
      3'b101:  dec_ctrl = OpSw;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_mc = (dec_ctrl == OpMult) || (dec_ctrl == OpDivu);
  assign go     = !rst_i && (state_q == StIdle) && bus.valid_i && !bus.flush_i && dec_mc;

  // Reset forces every output to its idle value in the same cycle.
  always_comb begin
    bus.ALUCtrl_o  = OpNop;
    bus.mc_start_o = 1'b0;
    bus.mc_step_o  = 1'b0;
    bus.mc_last_o  = 1'b0;
    bus.stall_o    = 1'b0;
    bus.illegal_o  = 1'b0;
    if (!rst_i) begin
      if (state_q == StIdle) begin
        bus.ALUCtrl_o  = dec_ctrl;
        bus.illegal_o  = bus.valid_i && dec_illegal;
        bus.mc_start_o = go;
        bus.mc_step_o  = go;
        bus.stall_o    = go;
      end else begin
        bus.ALUCtrl_o = op_q;
        if (!bus.flush_i) begin
          bus.mc_step_o = 1'b1;
          if (cnt_q != '0) begin
            bus.stall_o = 1'b1;
          end else begin
            bus.mc_last_o = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StBusy;
          op_d    = dec_ctrl;
          cnt_d   = (dec_ctrl == OpMult) ? MulLoad : DivLoad;
        end
      end
      StBusy: begin
        if (bus.flush_i) begin
          state_d = StIdle;
          op_d    = OpNop;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_mcops_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_mcops_q <= '0;
    end else begin
      if (bus.stall_o && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (bus.mc_last_o && (perf_mcops_q != 32'hFFFF_FFFF)) begin
        perf_mcops_q <= perf_mcops_q + 32'd1;
      end
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_mcops_o = perf_mcops_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: cycle-by-cycle reference model plus
// directed vectors with hand-computed expectations.
module tb_alu_ctrl_mc;
  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_mc_if #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4)) bus ();

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_mcops;
`endif

  alu_ctrl_mc #(
    .FUNCT_W(6),
    .ALUOP_W(3),
    .CTRL_W (4),
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_stall_o(perf_stall),
    .perf_mcops_o(perf_mcops)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Returns {illegal, ctrl} straight from the decode tables.
  function automatic logic [4:0] ref_decode(input logic [2:0] aluop, input logic [5:0] funct);
    case (aluop)
      3'b000: return {1'b0, 4'b0110};
      3'b001: return {1'b0, 4'b1001};
      3'b011: return {1'b0, 4'b0101};
      3'b100: return {1'b0, 4'b1000};
      3'b101: return {1'b0, 4'b0111};
      3'b010: begin
        case (funct)
          6'b100000: return {1'b0, 4'b0000};
          6'b100010: return {1'b0, 4'b0001};
          6'b100100: return {1'b0, 4'b0010};
          6'b100101: return {1'b0, 4'b0011};
          6'b101010: return {1'b0, 4'b0100};
          6'b000000: return {1'b0, 4'b1100};
          6'b000010: return {1'b0, 4'b1101};
          6'b011000: return {1'b0, 4'b1010};
          6'b011011: return {1'b0, 4'b1011};
          default:   return {1'b1, 4'b1111};
        endcase
      end
      default: return {1'b1, 4'b1111};
    endcase
  endfunction

  // Model: an op in flight is described by its kind and its age in cycles
  // (age 0 is the issue cycle, seen while the model is not yet active).
  bit         m_active = 1'b0;
  logic [3:0] m_op     = 4'b1111;
  int         m_age    = 0;

  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'b1010) ? int'(MulLat) : int'(DivLat);
  endfunction

  function automatic bit ref_start();
    logic [4:0] d;
    d = ref_decode(bus.ALUOp_i, bus.funct_i);
    return !rst && !m_active && bus.valid_i && !bus.flush_i &&
           (d[3:0] == 4'b1010 || d[3:0] == 4'b1011);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_op     = 4'b1111;
    end else if (!m_active) begin
      if (ref_start()) begin
        m_active = 1'b1;
        m_op     = ref_decode(bus.ALUOp_i, bus.funct_i) ;
        m_age    = 1;
      end
    end else if (bus.flush_i || m_age == lat_of(m_op) - 1) begin
      m_active = 1'b0;
      m_op     = 4'b1111;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_ctrl;
    logic       e_start, e_step, e_last, e_stall, e_ill;
    logic [4:0] d;
    e_ctrl = 4'b1111;
    {e_start, e_step, e_last, e_stall, e_ill} = '0;
    if (!rst) begin
      if (!m_active) begin
        d       = ref_decode(bus.ALUOp_i, bus.funct_i);
        e_ctrl  = d[3:0];
        e_ill   = bus.valid_i & d[4];
        e_start = ref_start();
        e_step  = e_start;
        e_stall = e_start;
      end else begin
        e_ctrl = m_op;
        if (!bus.flush_i) begin
          e_step  = 1'b1;
          e_stall = (m_age <= lat_of(m_op) - 2);
          e_last  = (m_age == lat_of(m_op) - 1);
        end
      end
    end
    check("model_ctrl", 32'(bus.ALUCtrl_o), 32'(e_ctrl));
    check("model_start", 32'(bus.mc_start_o), 32'(e_start));
    check("model_step", 32'(bus.mc_step_o), 32'(e_step));
    check("model_last", 32'(bus.mc_last_o), 32'(e_last));
    check("model_stall", 32'(bus.stall_o), 32'(e_stall));
    check("model_illegal", 32'(bus.illegal_o), 32'(e_ill));
  end

  task automatic drive(input logic r, input logic v, input logic fl, input logic [2:0] op,
                       input logic [5:0] fn);
    @(posedge clk);
    #1;
    rst         = r;
    bus.valid_i = v;
    bus.flush_i = fl;
    bus.ALUOp_i = op;
    bus.funct_i = fn;
    @(negedge clk);
    #1;
  endtask

  // Literal checks of {ctrl, start, step, last, stall, illegal}.
  task automatic lit(input string name, input logic [8:0] exp);
    check(name, 32'({bus.ALUCtrl_o, bus.mc_start_o, bus.mc_step_o, bus.mc_last_o,
                     bus.stall_o, bus.illegal_o}), 32'(exp));
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDivu = 6'b011011;
  localparam logic [5:0] FnAdd  = 6'b100000;

  vec_t vecs[15] = '{
    '{3'b010, 6'b100000, 4'b0000, 1'b0},
    '{3'b010, 6'b100010, 4'b0001, 1'b0},
    '{3'b010, 6'b100100, 4'b0010, 1'b0},
    '{3'b010, 6'b100101, 4'b0011, 1'b0},
    '{3'b010, 6'b101010, 4'b0100, 1'b0},
    '{3'b010, 6'b000000, 4'b1100, 1'b0},
    '{3'b010, 6'b000010, 4'b1101, 1'b0},
    '{3'b000, 6'b111111, 4'b0110, 1'b0},
    '{3'b001, 6'b000000, 4'b1001, 1'b0},
    '{3'b011, 6'b000000, 4'b0101, 1'b0},
    '{3'b100, 6'b000000, 4'b1000, 1'b0},
    '{3'b101, 6'b000000, 4'b0111, 1'b0},
    '{3'b010, 6'b111111, 4'b1111, 1'b1},
    '{3'b110, 6'b100000, 4'b1111, 1'b1},
    '{3'b111, 6'b000000, 4'b1111, 1'b1}
  };

  initial begin
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.ALUOp_i = 3'b110;
    bus.funct_i = 6'b000000;
    // Reset with an illegal valid instruction on the inputs: outputs stay idle.
    drive(1'b1, 1'b1, 1'b0, 3'b110, 6'b000000);
    lit("reset_idle", {4'b1111, 5'b00000});

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, 1'b0, vecs[i].op, vecs[i].fn);
      lit($sformatf("decode_%0d", i), {vecs[i].ctrl, 4'b0000, vecs[i].ill});
    end

    // MULT, funct changed mid-op.
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    lit("mult_c0", {4'b1010, 5'b11010});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("mult_c1", {4'b1010, 5'b01010});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("mult_c2", {4'b1010, 5'b01010});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("mult_c3", {4'b1010, 5'b01100});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("mult_c4", {4'b0000, 5'b00000});

    // DIVU flushed at cycle 2.
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnDivu);
    lit("divu_c0", {4'b1011, 5'b11010});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnDivu);
    lit("divu_c1", {4'b1011, 5'b01010});
    drive(1'b0, 1'b0, 1'b1, 3'b010, FnDivu);
    lit("divu_flush", {4'b1011, 5'b00000});
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnAdd);
    lit("divu_after", {4'b0000, 5'b00000});

    // Back-to-back MULT with valid held high, then reset mid-op.
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_a_c0", {4'b1010, 5'b11010});
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_a_c1", {4'b1010, 5'b01010});
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_a_last", {4'b1010, 5'b01100});
    drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_b_start", {4'b1010, 5'b11010});
    drive(1'b1, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_rst_c1", {4'b1111, 5'b00000});
    drive(1'b1, 1'b1, 1'b0, 3'b010, FnMult);
    lit("b2b_rst_held", {4'b1111, 5'b00000});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("after_rst_0", {4'b0000, 5'b00000});
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    lit("after_rst_1", {4'b0000, 5'b00000});

    // Two MULT ops for the performance counters.
    drive(1'b1, 1'b0, 1'b0, 3'b010, FnAdd);
    repeat (2) begin
      drive(1'b0, 1'b1, 1'b0, 3'b010, FnMult);
      repeat (MulLat - 1) drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b010, FnAdd);
`ifdef ALU_CTRL_PERF_EN
    check("perf_stall", perf_stall, 32'd6);
    check("perf_mcops", perf_mcops, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Next-generation ALU controller for the CPU datapath: decodes ALUOp_i/funct_i into ALUCtrl_o and adds sequencing for multi-cycle operations (MULT, DIVU).
- Sits between the main decoder and the ALU / iterative mul-div unit.
- Drives stall_o to the PC/pipeline-hold logic and start/step/last strobes to the iterative unit.
- Single-cycle operations behave exactly as in the previous controller, with zero added latency.

Parameters:
- FUNCT_W, 6, funct field width.
- ALUOP_W, 3, ALUOp width.
- CTRL_W, 4, ALUCtrl width.
- MUL_LAT, 32, total cycles for MULT; must be at least 2.
- DIV_LAT, 33, total cycles for DIVU; must be at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instruction at inputs is valid this cycle.
- flush_i  in  1  abort in-flight multi-cycle op.
- funct_i  in  FUNCT_W  R-type funct.
- ALUOp_i  in  ALUOP_W  from decoder.
- ALUCtrl_o  out  CTRL_W  ALU operation select.
- mc_start_o  out  1  first cycle of multi-cycle op.
- mc_step_o  out  1  iterative unit advance enable.
- mc_last_o  out  1  final cycle; result valid, instruction retires.
- stall_o  out  1  hold PC/instruction.
- illegal_o  out  1  undecodable ALUOp/funct.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- While rst_i is high:
  - ALUCtrl_o=4'b1111 (NOP).
  - All strobes, stall_o and illegal_o are 0.
  - State=IDLE, counter=0, latched op=4'b1111.
- Encodings:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, ADDI 0101, LW 0110, SW 0111, SLTI 1000, BEQ 1001.
  - MULT 1010, DIVU 1011, SLL 1100, SRL 1101, NOP 1111.
- ALUOp mapping: 000 LW; 001 BEQ; 010 R-type; 011 ADDI; 100 SLTI; 101 SW; 110/111 illegal.
- R-type funct mapping: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 101010 SLT; 000000 SLL; 000010 SRL; 011000 MULT; 011011 DIVU; any other funct illegal.
- Illegal decode: ALUCtrl_o=NOP. illegal_o=valid_i, combinational. No state change.
- FSM states: IDLE, BUSY.
- IDLE:
  - ALUCtrl_o is the combinational decode of the inputs, regardless of valid_i.
  - valid_i=1, flush_i=0 and decode is MULT/DIVU:
    - mc_start_o=1, mc_step_o=1, stall_o=1.
    - Latch op.
    - Load counter with LAT-2.
    - Go to BUSY.
  - Otherwise all strobes and stall_o are 0.
- BUSY:
  - ALUCtrl_o equals the latched op; input changes are ignored.
  - valid_i is ignored.
  - mc_step_o=1 every cycle.
  - If counter≠0: stall_o=1 and the counter decrements.
  - If counter=0: mc_last_o=1, stall_o=0, next state IDLE.
- Timing: a multi-cycle op occupies exactly LAT cycles (cycle 0 in IDLE, 1..LAT-1 in BUSY).
  - stall_o is high on cycles 0..LAT-2.
  - mc_last_o is high on cycle LAT-1 only.
- flush_i in BUSY:
  - Has priority over everything except reset, including the last cycle.
  - mc_last_o=0, mc_step_o=0, stall_o=0.
  - Next state IDLE, latched op=NOP.
- Back-to-back: a multi-cycle op may start in the IDLE cycle directly after mc_last_o.
- Counter width: $clog2 of max(MUL_LAT, DIV_LAT), plus 1. No wrap: it is never decremented below 0.
- Reset mid-op: next cycle is IDLE with all outputs at their reset values; no mc_last_o is issued.

Optional Feature:
- Macro ALU_CTRL_PERF_EN.
- Defined: adds output ports perf_stall_o[31:0] and perf_mcops_o[31:0].
  - perf_stall_o counts cycles with stall_o=1.
  - perf_mcops_o counts mc_last_o pulses.
  - Both saturate at 32'hFFFFFFFF and clear on rst_i.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- ALUOp 010 with each legal funct, plus ALUOp 000/001/011/100/101, valid_i=1 -> same-cycle ALUCtrl_o per table; stall_o=0, illegal_o=0.
- ALUOp 010, funct 111111, valid_i=1 -> ALUCtrl_o=1111, illegal_o=1. ALUOp 110 -> same.
- MUL_LAT=4, MULT issued at cycle 0 -> mc_start_o at cycle 0 only; stall_o at cycles 0-2; mc_last_o at cycle 3; ALUCtrl_o=1010 throughout even with funct_i changed at cycle 1.
- DIVU (DIV_LAT=5) with flush_i at cycle 2 -> stall_o=0 at cycle 2, no mc_last_o; IDLE at cycle 3 decodes ADD=0000.
- MULT, then MULT again in the cycle after mc_last_o, then rst_i at cycle 1 of the second op -> second mc_start_o present; at the cycle after reset all outputs=0 and ALUCtrl_o=1111 while rst_i is held.
- With ALU_CTRL_PERF_EN, two MULT ops (MUL_LAT=4) -> perf_stall_o=6, perf_mcops_o=2.
